// File: rtl/ddram_pcm_loader.sv
// ddram_pcm_loader: captures the PCM slice of the ROM download and writes it to DDRAM as 64-bit words.
module ddram_pcm_loader #(
  parameter logic [24:0] PCM_START  = 25'h40000,
  parameter logic [24:0] PCM_SIZE   = 25'h40000,
  parameter logic [28:0] DDR_BASE   = 29'h0300_0000,
  parameter logic [7:0]  LOAD_INDEX = 8'd0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  input  logic        DDRAM_BUSY,
  output logic [28:0] DDRAM_ADDR,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic        done
);
  localparam logic [25:0] PCM_END = {1'b0, PCM_START} + {1'b0, PCM_SIZE};
  logic [63:0] acc_word, m_word, f_word, n_word;
  logic [7:0]  acc_be, m_be, f_be, n_be;
  logic [28:0] acc_addr, f_addr, n_addr, b_addr;
  logic        skid_v, dl_q, loading;
  logic [17:0] skid_off, cap_off, b_off;
  logic [7:0]  skid_dat, b_dat;
  logic [2:0]  b_lane;
  logic        cap, bv, out_free, conflict, consumed, flush, clr;
  assign ioctl_wait     = DDRAM_WE;
  assign DDRAM_BURSTCNT = 8'd1;
  assign cap      = ioctl_wr && ioctl_download && ioctl_index == LOAD_INDEX &&
                    ioctl_addr >= PCM_START && {1'b0, ioctl_addr} < PCM_END;
  assign cap_off  = ioctl_addr[17:0] - PCM_START[17:0];
  // A held skid byte always goes ahead of a newly arriving one.
  assign bv       = skid_v || cap;
  assign b_off    = skid_v ? skid_off : cap_off;
  assign b_dat    = skid_v ? skid_dat : ioctl_dout;
  assign b_lane   = b_off[2:0];
  assign b_addr   = DDR_BASE + 29'(b_off[17:3]);
  assign out_free = !DDRAM_WE;
  always_comb begin
    conflict = bv && acc_be != 8'd0 && b_addr != acc_addr;
    m_word = conflict ? 64'd0 : acc_word;
    m_word[{b_lane, 3'b000} +: 8] = b_dat;
    m_be = (conflict ? 8'd0 : acc_be) | (8'd1 << b_lane);
    consumed = bv && (out_free || (!conflict && !m_be[7]));
    flush = out_free && (bv ? (conflict || m_be[7])
                            : (acc_be != 8'd0 && (acc_be[7] || !ioctl_download)));
    f_word = (bv && !conflict) ? m_word : acc_word;
    f_be   = (bv && !conflict) ? m_be : acc_be;
    f_addr = (bv && !conflict) ? b_addr : acc_addr;
    clr    = flush && !(consumed && conflict);
    n_word = clr ? 64'd0 : consumed ? m_word : acc_word;
    n_be   = clr ? 8'd0 : consumed ? m_be : acc_be;
    n_addr = clr ? 29'd0 : consumed ? b_addr : acc_addr;
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      acc_word   <= '0;
      acc_be     <= '0;
      acc_addr   <= '0;
      skid_v     <= 1'b0;
      skid_off   <= '0;
      skid_dat   <= '0;
      DDRAM_WE   <= 1'b0;
      DDRAM_ADDR <= '0;
      DDRAM_DIN  <= '0;
      DDRAM_BE   <= '0;
      dl_q       <= 1'b0;
      loading    <= 1'b0;
      done       <= 1'b0;
    end else begin
      acc_word <= n_word;
      acc_be   <= n_be;
      acc_addr <= n_addr;
      skid_v   <= skid_v ? (consumed ? cap : 1'b1) : (cap && !consumed);
      if (cap && skid_v == consumed) begin
        skid_off <= cap_off;
        skid_dat <= ioctl_dout;
      end
      if (flush) begin
        DDRAM_WE   <= 1'b1;
        DDRAM_ADDR <= f_addr;
        DDRAM_DIN  <= f_word;
        DDRAM_BE   <= f_be;
      end else if (DDRAM_WE && !DDRAM_BUSY) DDRAM_WE <= 1'b0;
      dl_q <= ioctl_download;
      // done is only armed by a matching download so other indices leave it alone.
      if (ioctl_download && !dl_q && ioctl_index == LOAD_INDEX) begin
        loading <= 1'b1;
        done    <= 1'b0;
      end else if (loading && !ioctl_download && acc_be == 8'd0 && !skid_v && !DDRAM_WE) begin
        loading <= 1'b0;
        done    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ddram_pcm_loader.sv
// tb_ddram_pcm_loader: directed vectors for the PCM loader against a byte-level DDRAM model.
module tb_ddram_pcm_loader;
  localparam logic [24:0] S = 25'h40000;
  localparam logic [24:0] SZ = 25'h40000;
  localparam logic [28:0] BASE = 29'h0300_0000;
  typedef struct { logic [28:0] a; logic [63:0] d; logic [7:0] be; } wr_t;
  logic        clk_sys = 1'b0, reset = 1'b1;
  logic        ioctl_download = 1'b0, ioctl_wr = 1'b0, ioctl_wait;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0, ioctl_index = '0;
  logic        DDRAM_BUSY = 1'b0, DDRAM_WE, done;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE, DDRAM_BURSTCNT;
  int nvec = 0, nmis = 0;
  int nwr = 0, n_partial = 0, done_rises = 0;
  logic done_q = 1'b0, rnd_busy = 1'b0;
  wr_t wq[$];
  logic [7:0] mem [0:262143];
  logic [7:0] img [0:4159];
  ddram_pcm_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .ioctl_wait(ioctl_wait), .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_ADDR(DDRAM_ADDR),
    .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE),
    .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .done(done)
  );
  always #5 clk_sys = ~clk_sys;
  // Inputs change just after posedge, so the negedge view is what the next edge will accept.
  always @(negedge clk_sys) begin
    logic [28:0] wd;
    if (DDRAM_WE && !DDRAM_BUSY && !reset) begin
      wq.push_back('{DDRAM_ADDR, DDRAM_DIN, DDRAM_BE});
      nwr++;
      if (DDRAM_BE != 8'hFF) n_partial++;
      wd = DDRAM_ADDR - BASE;
      for (int l = 0; l < 8; l++)
        if (DDRAM_BE[l]) mem[{wd[14:0], 3'(l)}] = DDRAM_DIN[l*8 +: 8];
    end
    if (done && !done_q) done_rises++;
    done_q = done;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_sys);
    #1;
    if (rnd_busy) DDRAM_BUSY = ($urandom_range(0, 2) == 0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick;
  endtask
  task automatic send_raw(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    tick;
    ioctl_wr = 1'b0;
  endtask
  task automatic send(input logic [24:0] a, input logic [7:0] d);
    for (int n = 0; ioctl_wait && n < 200; n++) tick;
    if (ioctl_wait) chk("wait_timeout", 1, 0);
    send_raw(a, d);
  endtask
  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick;
  endtask
  task automatic end_dl;
    ioctl_download = 1'b0;
    tick;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int base, w0, d0, r0;
    logic [24:0] off;
    idle(2);
    chk("rst_we", DDRAM_WE, 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_done", done, 0);
    chk("rst_be", DDRAM_BE, 0);
    chk("rst_addr", DDRAM_ADDR, 0);
    chk("rst_din", DDRAM_DIN, 0);
    chk("burstcnt", DDRAM_BURSTCNT, 8'd1);
    reset = 1'b0;
    idle(2);
    // Sequential 16 bytes: two full words.
    base = wq.size();
    start_dl(8'd0);
    for (int i = 0; i < 16; i++) send(S + 25'(i), 8'(i));
    end_dl;
    idle(10);
    chk("seq_count", wq.size() - base, 2);
    chk("seq_a0", wq[base].a, 29'h0300_0000);
    chk("seq_d0", wq[base].d, 64'h0706050403020100);
    chk("seq_be0", wq[base].be, 8'hFF);
    chk("seq_a1", wq[base+1].a, 29'h0300_0001);
    chk("seq_d1", wq[base+1].d, 64'h0F0E0D0C0B0A0908);
    chk("seq_be1", wq[base+1].be, 8'hFF);
    chk("seq_done", done, 1);
    // Sparse bytes: word-change flush, then download-end flush.
    base = wq.size();
    start_dl(8'd0);
    chk("done_clear", done, 0);
    send(S + 25'd3, 8'hAA);
    send(S + 25'd9, 8'hBB);
    idle(4);
    chk("sp_count1", wq.size() - base, 1);
    chk("sp_a0", wq[base].a, 29'h0300_0000);
    chk("sp_be0", wq[base].be, 8'h08);
    chk("sp_d0", wq[base].d[31:24], 8'hAA);
    chk("sp_done_lo", done, 0);
    end_dl;
    idle(6);
    chk("sp_count2", wq.size() - base, 2);
    chk("sp_a1", wq[base+1].a, 29'h0300_0001);
    chk("sp_be1", wq[base+1].be, 8'h02);
    chk("sp_d1", wq[base+1].d[15:8], 8'hBB);
    chk("sp_done", done, 1);
    // BUSY stall for 20 cycles with an extra byte pushed in during the stall.
    base = wq.size();
    start_dl(8'd0);
    DDRAM_BUSY = 1'b1;
    for (int i = 0; i < 8; i++) send(S + 25'(16 + i), 8'h10 + 8'(i));
    send_raw(S + 25'd24, 8'h55);
    for (int i = 0; i < 20; i++) begin
      chk("stall_ctl", {DDRAM_WE, ioctl_wait, DDRAM_BE}, {2'b11, 8'hFF});
      chk("stall_dat", {DDRAM_ADDR, DDRAM_DIN}, {29'h0300_0002, 64'h1716151413121110});
      tick;
    end
    DDRAM_BUSY = 1'b0;
    tick;
    end_dl;
    idle(6);
    chk("stall_count", wq.size() - base, 2);
    chk("stall_d0", wq[base].d, 64'h1716151413121110);
    chk("stall_a1", wq[base+1].a, 29'h0300_0003);
    chk("stall_be1", wq[base+1].be, 8'h01);
    chk("stall_d1", wq[base+1].d[7:0], 8'h55);
    // Other index and out-of-window bytes never reach DDRAM.
    base = wq.size();
    start_dl(8'd254);
    chk("dip_done", done, 1);
    send(S, 8'h77);
    end_dl;
    idle(4);
    chk("dip_done2", done, 1);
    start_dl(8'd0);
    send(S - 25'd1, 8'h11);
    send(S + SZ, 8'h22);
    end_dl;
    idle(6);
    chk("oow_count", wq.size() - base, 0);
    chk("oow_done", done, 1);
    // Asynchronous reset with a write pending under BUSY.
    base = wq.size();
    start_dl(8'd0);
    DDRAM_BUSY = 1'b1;
    for (int i = 0; i < 8; i++) send(S + 25'(32 + i), 8'hC0 + 8'(i));
    send_raw(S + 25'd40, 8'hEE);
    chk("pre_rst_we", DDRAM_WE, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_we", DDRAM_WE, 0);
    chk("arst_wait", ioctl_wait, 0);
    chk("arst_be", DDRAM_BE, 0);
    chk("arst_done", done, 0);
    idle(2);
    ioctl_download = 1'b0;
    DDRAM_BUSY = 1'b0;
    reset = 1'b0;
    idle(20);
    chk("arst_count", wq.size() - base, 0);
    chk("arst_we2", DDRAM_WE, 0);
    // Image slices at both ends of the region under random BUSY.
    for (int i = 0; i < 4160; i++) img[i] = 8'($urandom);
    w0 = nwr;
    d0 = n_partial;
    r0 = done_rises;
    rnd_busy = 1'b1;
    start_dl(8'd0);
    for (int i = 0; i < 4160; i++) begin
      off = (i < 4096) ? 25'(i) : 25'(262080 + i - 4096);
      send(S + off, img[i]);
    end
    end_dl;
    for (int n = 0; !done && n < 500; n++) tick;
    rnd_busy = 1'b0;
    DDRAM_BUSY = 1'b0;
    idle(4);
    chk("img_done", done, 1);
    chk("img_writes", nwr - w0, 520);
    chk("img_partial", n_partial - d0, 0);
    chk("img_done_rises", done_rises - r0, 1);
    for (int i = 0; i < 4160; i++)
      chk("img_byte", mem[(i < 4096) ? i : 262080 + i - 4096], img[i]);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
